axi_read_rr_arbiter: RTL

Round-robin arbiter that shares one AXI4 read channel (AR + R) between two requesters: port 0 (instruction fetch) and port 1 (LSU/memory stage). It sits between the IF/MEM read masters and the single downstream io read port. It holds at most one outstanding burst and locks the grant until the last data beat completes. It also checks the beat count against `arlen` and reports a sticky protocol-error flag.

---
 rtl/axi_read_rr_arbiter_if.sv | 32 +++
 rtl/axi_read_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axi_read_rr_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the upstream requesters and the
// downstream io read port.
interface axi_read_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_read_rr_arbiter.sv
// Two-port round-robin arbiter for one AXI4 read channel: one burst in flight,
// grant locked until rlast, sticky beat-count mismatch flag.
module axi_read_rr_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_read_rr_arbiter_if.slave  m0,
  axi_read_rr_arbiter_if.slave  m1,
  axi_read_rr_arbiter_if.master s,
  output logic                  grant_id,
  output logic                  len_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              grant_q, grant_d;
  logic              len_err_q, len_err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ID_W-1:0]   arid_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic              winner;
  logic              ar_hs;
  logic              in_data;
  logic              rready_c;
  logic              r_beat;

  // On a tie the port that did not own the previous burst wins.
  always_comb begin
    winner   = (m0.arvalid && m1.arvalid) ? ~last_gnt_q : m1.arvalid;
    ar_hs    = (state_q == StIdle) && (m0.arvalid || m1.arvalid) && !rst;
    in_data  = (state_q == StData) && !rst;
    rready_c = in_data && (grant_q ? m1.rready : m0.rready);
    r_beat   = in_data && s.rvalid && rready_c;
  end

  assign m0.arready = ar_hs && !winner;
  assign m1.arready = ar_hs && winner;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    grant_d    = grant_q;
    len_err_d  = len_err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          grant_d = winner;
          cnt_d   = winner ? m1.arlen : m0.arlen;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (s.arready) state_d = StData;
      end
      StData: begin
        if (r_beat) begin
          // Only rlast ends the burst; a count mismatch is just recorded.
          if ((cnt_q == 8'd0) != s.rlast) len_err_d = 1'b1;
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (s.rlast) begin
            state_d    = StIdle;
            last_gnt_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      grant_q    <= 1'b0;
      len_err_q  <= 1'b0;
      cnt_q      <= 8'd0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      grant_q    <= grant_d;
      len_err_q  <= len_err_d;
      cnt_q      <= cnt_d;
      arvalid_q  <= (state_d == StAddr);
      if (ar_hs) begin
        araddr_q  <= winner ? m1.araddr  : m0.araddr;
        arid_q    <= winner ? m1.arid    : m0.arid;
        arlen_q   <= winner ? m1.arlen   : m0.arlen;
        arsize_q  <= winner ? m1.arsize  : m0.arsize;
        arburst_q <= winner ? m1.arburst : m0.arburst;
      end
    end
  end

  assign s.arvalid = arvalid_q;
  assign s.araddr  = araddr_q;
  assign s.arid    = arid_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;
  assign s.rready  = rready_c;

  assign grant_id  = grant_q;
  assign len_err   = len_err_q;

  // R is steered by the grant, not by rid; the idle side sees all zeros.
  always_comb begin
    m0.rvalid = 1'b0;
    m0.rdata  = '0;
    m0.rresp  = '0;
    m0.rlast  = 1'b0;
    m0.rid    = '0;
    m1.rvalid = 1'b0;
    m1.rdata  = '0;
    m1.rresp  = '0;
    m1.rlast  = 1'b0;
    m1.rid    = '0;
    if (in_data && !grant_q) begin
      m0.rvalid = s.rvalid;
      m0.rdata  = s.rdata;
      m0.rresp  = s.rresp;
      m0.rlast  = s.rlast;
      m0.rid    = s.rid;
    end
    if (in_data && grant_q) begin
      m1.rvalid = s.rvalid;
      m1.rdata  = s.rdata;
      m1.rresp  = s.rresp;
      m1.rlast  = s.rlast;
      m1.rid    = s.rid;
    end
  end

endmodule
